// File: rtl/s2_conv_scheduler_if.sv
// Control, datapath and stream signals between s2_conv_scheduler (master) and its environment (slave).
interface s2_conv_scheduler_if;
    localparam int unsigned NFILT = 4;
    localparam int unsigned NPOS  = 36;
    localparam int unsigned RW    = 36;
    localparam int unsigned NRES  = NFILT * NPOS;

    logic               start;
    logic               abort;
    logic [1:0]         proc_dir;
    logic [5:0]         proc_counter;
    logic               proc_valid;
    logic [NRES*RW-1:0] res_vec;
    logic [RW-1:0]      out_data;
    logic [7:0]         out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;

    modport master (
        input  start, abort, res_vec, out_ready,
        output proc_dir, proc_counter, proc_valid, out_data, out_idx, out_valid, busy, done
    );
    modport slave (
        output start, abort, res_vec, out_ready,
        input  proc_dir, proc_counter, proc_valid, out_data, out_idx, out_valid, busy, done
    );
endinterface

// File: rtl/s2_conv_scheduler.sv
// Stage-2 scheduler: walks 4 filters x 36 positions, buffers one result word per cycle, streams 144 words.
// Optional macro S2_SCHED_RESULT_PIPE_EN: capture res_vec one cycle after the address, adds a FLUSH cycle.
module s2_conv_scheduler (
    input  logic                clk,
    input  logic                rst,
    s2_conv_scheduler_if.master bus_io
);
    localparam int unsigned NFILT = 4;
    localparam int unsigned NPOS  = 36;
    localparam int unsigned NCOL  = 6;
    localparam int unsigned RW    = 36;
    localparam int unsigned NRES  = NFILT * NPOS;
    localparam int unsigned IW    = 8;
    localparam int unsigned VW    = $clog2(NRES * RW);

`ifdef S2_SCHED_RESULT_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, STREAM = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STREAM = 2'd3} state_e;
`endif

    state_e        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic          proc_valid_q, proc_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RW-1:0] buf_q [NRES];

    logic [IW-1:0] drv_idx;
    logic [IW-1:0] nxt_idx;
    logic          last_pos;
    logic          hs;
    logic          cap_en;
    logic [IW-1:0] cap_idx;
    logic [VW-1:0] cap_bit;

    assign drv_idx  = IW'(dir_q) * IW'(NPOS) + IW'(row_q) * IW'(NCOL) + IW'(col_q);
    assign nxt_idx  = out_idx_q + IW'(1);
    assign last_pos = proc_valid_q && (dir_q == 2'd3) && (row_q == 3'd5) && (col_q == 3'd5);
    assign hs       = out_valid_q && bus_io.out_ready;

`ifdef S2_SCHED_RESULT_PIPE_EN
    // Datapath result lags its address by one cycle, so the capture address is delayed to match.
    logic          cap_vld_q, cap_vld_d;
    logic [IW-1:0] cap_idx_q, cap_idx_d;

    assign cap_vld_d = proc_valid_q && !bus_io.abort;
    assign cap_idx_d = drv_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign cap_en  = cap_vld_q;
    assign cap_idx = cap_idx_q;
`else
    assign cap_en  = proc_valid_q;
    assign cap_idx = drv_idx;
`endif

    assign cap_bit = VW'(cap_idx) * VW'(RW);

    // Result buffer: filled during RUN, read during STREAM; abort keeps contents, reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NRES; i++) buf_q[i] <= '0;
        end else if (cap_en) begin
            buf_q[cap_idx] <= bus_io.res_vec[cap_bit +: RW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            proc_valid_q <= 1'b0;
            out_idx_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            row_q        <= row_d;
            col_q        <= col_d;
            proc_valid_q <= proc_valid_d;
            out_idx_q    <= out_idx_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        row_d        = row_q;
        col_d        = col_q;
        proc_valid_d = proc_valid_q;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    state_d      = RUN;
                    proc_valid_d = 1'b1;
                    dir_d        = '0;
                    row_d        = '0;
                    col_d        = '0;
                end
            end
            RUN: begin
                if (last_pos) begin
                    proc_valid_d = 1'b0;
                    dir_d        = '0;
                    row_d        = '0;
                    col_d        = '0;
`ifdef S2_SCHED_RESULT_PIPE_EN
                    state_d      = FLUSH;
`else
                    state_d      = STREAM;
                    out_valid_d  = 1'b1;
                    out_idx_d    = '0;
                    out_data_d   = buf_q[0];
`endif
                end else if (col_q == 3'd5) begin
                    col_d = '0;
                    if (row_q == 3'd5) begin
                        row_d = '0;
                        dir_d = dir_q + 2'd1;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
`ifdef S2_SCHED_RESULT_PIPE_EN
            FLUSH: begin
                state_d     = STREAM;
                out_valid_d = 1'b1;
                out_idx_d   = '0;
                out_data_d  = buf_q[0];
            end
`endif
            STREAM: begin
                if (hs) begin
                    if (out_idx_q == IW'(NRES - 1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        out_idx_d  = nxt_idx;
                        out_data_d = buf_q[nxt_idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort dominates everything, including a start in the same cycle.
        if (bus_io.abort) begin
            state_d      = IDLE;
            dir_d        = '0;
            row_d        = '0;
            col_d        = '0;
            proc_valid_d = 1'b0;
            out_idx_d    = '0;
            out_data_d   = '0;
            out_valid_d  = 1'b0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus_io.proc_dir     = dir_q;
    assign bus_io.proc_counter = {row_q, col_q};
    assign bus_io.proc_valid   = proc_valid_q;
    assign bus_io.out_data     = out_data_q;
    assign bus_io.out_idx      = out_idx_q;
    assign bus_io.out_valid    = out_valid_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
endmodule

// File: tb/tb_s2_conv_scheduler.sv
// Bench for s2_conv_scheduler: directed frames with random data and random back-pressure against a reference map.
module tb_s2_conv_scheduler;
    localparam int unsigned NRES = 144;
    localparam int unsigned RW   = 36;
`ifdef S2_SCHED_RESULT_PIPE_EN
    localparam int FRAME = 145;
`else
    localparam int FRAME = 144;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s2_conv_scheduler_if bus ();
    s2_conv_scheduler dut (.clk(clk), .rst(rst), .bus_io(bus.master));

    int checks = 0;
    int errors = 0;

    // Expected feature map: word at index dir*36+row*6+col.
    logic [RW-1:0] ref_mem [NRES];

    // Datapath model: returns the word for the addressed position (one cycle late when piped).
    logic [7:0] cur_idx;
    logic       rv_en;
    logic [7:0] rv_idx;
    assign cur_idx = 8'(bus.proc_dir) * 8'd36 + 8'(bus.proc_counter[5:3]) * 8'd6 + 8'(bus.proc_counter[2:0]);
`ifdef S2_SCHED_RESULT_PIPE_EN
    always @(posedge clk) begin
        rv_en  <= bus.proc_valid;
        rv_idx <= cur_idx;
    end
`else
    assign rv_en  = bus.proc_valid;
    assign rv_idx = cur_idx;
`endif
    always_comb begin
        bus.res_vec = '0;
        if (rv_en === 1'b1 && rv_idx < 8'(NRES))
            bus.res_vec[13'(rv_idx) * 13'd36 +: 36] = ref_mem[rv_idx];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 64'({bus.busy, bus.done, bus.proc_valid, bus.out_valid,
                      bus.proc_dir, bus.proc_counter, bus.out_idx, bus.out_data}), 64'd0);
    endtask

    task automatic fill(input bit incr);
        for (int i = 0; i < int'(NRES); i++)
            ref_mem[i] = incr ? RW'(i + 1) : {4'($urandom), 32'($urandom)};
    endtask

    // One frame from start; rmode 0=always ready, 1=toggle, 2=random. abort_at/rst_at < 0 disable.
    task automatic run_frame(input int rmode, input bit spam, input int abort_at, input int rst_at);
        int  k = 0, n = 0, cyc = 0, first_ov = -1;
        bit  exp_done = 1'b0, tog = 1'b0, hs, did_abort;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("run_start", 64'(bus.proc_valid), 64'd1);
        while (cyc < 1000) begin
            if (exp_done) begin
                bus.start = 1'b0;
                chk("done_pulse", 64'({bus.done, bus.busy, bus.out_valid}), 64'b100);
                @(negedge clk);
                chk_idle("post_done");
                return;
            end
            chk("done_low", 64'(bus.done), 64'd0);
            chk("busy", 64'(bus.busy), 64'd1);
            did_abort = 1'b0;
            if (bus.proc_valid) begin
                chk("pos", 64'({bus.proc_dir, bus.proc_counter}),
                    64'({2'(k / 36), 3'((k % 36) / 6), 3'(k % 6)}));
                if (k == abort_at) did_abort = 1'b1;
                k++;
            end
            if (bus.out_valid) begin
                if (first_ov < 0) begin
                    first_ov = cyc;
                    chk("run_len", 64'(first_ov), 64'(FRAME));
                    chk("pos_count", 64'(k), 64'(NRES));
                end
                chk("out_idx", 64'(bus.out_idx), 64'(n));
                chk("out_data", 64'(bus.out_data), 64'(ref_mem[n]));
                if (n == rst_at) begin
                    #2 rst = 1'b1;
                    #1 chk_idle("async_rst");
                    @(negedge clk);
                    rst = 1'b0;
                    chk_idle("rst_release");
                    return;
                end
            end
            tog = ~tog;
            bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
            bus.start = spam ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.abort = did_abort;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                n++;
                if (n == int'(NRES)) exp_done = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (did_abort) begin
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk_idle("abort");
                @(negedge clk);
                chk_idle("abort_hold");
                return;
            end
        end
        chk("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        fill(1'b1);
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk_idle("t1_idle");
        end

        run_frame(0, 1'b0, -1, -1);
        fill(1'b0);
        run_frame(1, 1'b0, -1, -1);
        fill(1'b0);
        run_frame(2, 1'b0, 50, -1);
        fill(1'b0);
        run_frame(0, 1'b0, -1, -1);
        fill(1'b0);
        run_frame(1, 1'b1, -1, -1);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_idle("start_abort");
        @(negedge clk);
        chk_idle("start_abort_hold");

        fill(1'b1);
        run_frame(0, 1'b0, -1, 70);
        repeat (2) @(negedge clk);
        run_frame(2, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
